// File: rtl/if_id_pkg.sv
// rtl/if_id_pkg.sv - shared types and instruction field positions for the fetch-to-decode stage
package if_id_pkg;

    localparam int INSTR_W  = 32;

    localparam int IMM_MSB  = 11;
    localparam int IMM_LSB  = 0;
    localparam int RD_MSB   = 15;
    localparam int RD_LSB   = 12;
    localparam int RN_MSB   = 19;
    localparam int RN_LSB   = 16;
    localparam int OP_MSB   = 27;
    localparam int OP_LSB   = 26;
    localparam int COND_MSB = 31;
    localparam int COND_LSB = 28;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/skid_buf2.sv
// rtl/skid_buf2.sv - generic 2-entry valid/ready skid buffer with synchronous flush
module skid_buf2
    import if_id_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic [W-1:0] s_tdata,
    input  logic         s_tvalid,
    output logic         s_tready,
    output logic [W-1:0] m_tdata,
    output logic         m_tvalid,
    input  logic         m_tready
);

    state_t       state, state_nxt;
    logic [W-1:0] head, head_nxt;
    logic [W-1:0] tail, tail_nxt;
    logic         push, pop;

    // Handshake qualifiers come from registered state only, so downstream
    // back-pressure never reaches the upstream ready combinationally.
    assign s_tready = (state != FULL);
    assign m_tvalid = (state != EMPTY);
    assign m_tdata  = head;

    assign push = s_tvalid & s_tready;
    assign pop  = m_tvalid & m_tready;

    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        tail_nxt  = tail;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        state_nxt = ONE;
                        head_nxt  = s_tdata;
                    end
                end
                ONE: begin
                    if (push && pop) begin
                        head_nxt = s_tdata;
                    end else if (push) begin
                        state_nxt = FULL;
                        tail_nxt  = s_tdata;
                    end else if (pop) begin
                        state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    if (pop) begin
                        state_nxt = ONE;
                        head_nxt  = tail;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    // Data registers are not cleared on pop or flush; consumers gate on m_tvalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= EMPTY;
            head  <= '0;
            tail  <= '0;
        end else begin
            state <= state_nxt;
            head  <= head_nxt;
            tail  <= tail_nxt;
        end
    end

endmodule

// File: rtl/if_id_skid_stage.sv
// rtl/if_id_skid_stage.sv - fetch-to-decode skid stage with field split; IF_ID_PERF_CNT_EN enables the stall counter
module if_id_skid_stage
    import if_id_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               Flush,
    input  logic [INSTR_W-1:0] InstrIn,
    input  logic [PC_W-1:0]    PCIn,
    input  logic               InstrValid,
    output logic               InstrReady,
    output logic               DecValid,
    input  logic               DecReady,
    output logic [INSTR_W-1:0] Instr,
    output logic [PC_W-1:0]    PCOut,
    output logic [11:0]        Imm,
    output logic [3:0]         Rd,
    output logic [3:0]         Rn,
    output logic [1:0]         Op,
    output logic [3:0]         Cond,
    output logic [31:0]        StallCount
);

    localparam int ENTRY_W = PC_W + INSTR_W;

    logic [ENTRY_W-1:0] head;

    skid_buf2 #(
        .W(ENTRY_W)
    ) u_buf (
        .clk      (clk),
        .reset    (reset),
        .flush    (Flush),
        .s_tdata  ({PCIn, InstrIn}),
        .s_tvalid (InstrValid),
        .s_tready (InstrReady),
        .m_tdata  (head),
        .m_tvalid (DecValid),
        .m_tready (DecReady)
    );

    assign Instr = head[INSTR_W-1:0];
    assign PCOut = head[ENTRY_W-1:INSTR_W];

    // Fields are raw slices; sign/zero extension belongs to the immediate extender.
    assign Imm  = Instr[IMM_MSB:IMM_LSB];
    assign Rd   = Instr[RD_MSB:RD_LSB];
    assign Rn   = Instr[RN_MSB:RN_LSB];
    assign Op   = Instr[OP_MSB:OP_LSB];
    assign Cond = Instr[COND_MSB:COND_LSB];

`ifdef IF_ID_PERF_CNT_EN
    logic [31:0] stall_cnt;

    // Saturating; only reset clears it so stalls survive pipeline flushes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (DecValid && !DecReady && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign StallCount = stall_cnt;
`else
    assign StallCount = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_skid_stage.sv
// tb/tb_if_id_skid_stage.sv - directed self-checking bench for if_id_skid_stage
module tb_if_id_skid_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        Flush;
    logic [31:0] InstrIn;
    logic [31:0] PCIn;
    logic        InstrValid;
    logic        InstrReady;
    logic        DecValid;
    logic        DecReady;
    logic [31:0] Instr;
    logic [31:0] PCOut;
    logic [11:0] Imm;
    logic [3:0]  Rd;
    logic [3:0]  Rn;
    logic [1:0]  Op;
    logic [3:0]  Cond;
    logic [31:0] StallCount;

    int n_cmp = 0;
    int n_err = 0;

`ifdef IF_ID_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    if_id_skid_stage #(.PC_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .Flush      (Flush),
        .InstrIn    (InstrIn),
        .PCIn       (PCIn),
        .InstrValid (InstrValid),
        .InstrReady (InstrReady),
        .DecValid   (DecValid),
        .DecReady   (DecReady),
        .Instr      (Instr),
        .PCOut      (PCOut),
        .Imm        (Imm),
        .Rd         (Rd),
        .Rn         (Rn),
        .Op         (Op),
        .Cond       (Cond),
        .StallCount (StallCount)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc);
        InstrValid = v;
        InstrIn    = ins;
        PCIn       = pc;
    endtask

    initial begin
        reset = 1'b1; Flush = 1'b0; DecReady = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        #1;
        chk("rst_decvalid", DecValid, 0);
        chk("rst_instr", Instr, 0);
        chk("rst_pc", PCOut, 0);
        chk("rst_imm", Imm, 0);
        chk("rst_cond", Cond, 0);
        chk("rst_stall", StallCount, 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("post_rst_ready", InstrReady, 1);
        chk("post_rst_decvalid", DecValid, 0);

        // single pass through an empty queue
        DecReady = 1'b1;
        drive(1'b1, 32'hE3A01005, 32'h100);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("p1_decvalid", DecValid, 1);
        chk("p1_imm", Imm, 12'h005);
        chk("p1_rd", Rd, 1);
        chk("p1_rn", Rn, 0);
        chk("p1_op", Op, 0);
        chk("p1_cond", Cond, 4'hE);
        chk("p1_pc", PCOut, 32'h100);
        tick();
        chk("p1_drained", DecValid, 0);
        chk("p1_hold_instr", Instr, 32'hE3A01005);

        // back-pressure fill then in-order drain
        DecReady = 1'b0;
        drive(1'b1, 32'hE2812001, 32'h104);
        tick();
        chk("bp_ready_one", InstrReady, 1);
        drive(1'b1, 32'hE2822002, 32'h108);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("bp_ready_full", InstrReady, 0);
        chk("bp_head", Instr, 32'hE2812001);
        chk("bp_imm", Imm, 12'h001);
        chk("bp_rd", Rd, 2);
        chk("bp_rn", Rn, 1);
        tick();
        chk("bp_stall_head", Instr, 32'hE2812001);
        chk("bp_stall_pc", PCOut, 32'h104);
        DecReady = 1'b1;
        tick();
        chk("bp_second", Instr, 32'hE2822002);
        chk("bp_second_pc", PCOut, 32'h108);
        chk("bp_second_valid", DecValid, 1);
        chk("bp_ready_again", InstrReady, 1);
        tick();
        chk("bp_empty", DecValid, 0);

        // simultaneous push/pop in ONE replaces the head
        DecReady = 1'b0;
        drive(1'b1, 32'hE3A0100A, 32'h200);
        tick();
        chk("pp_head", Imm, 12'h00A);
        DecReady = 1'b1;
        drive(1'b1, 32'hE3A020FF, 32'h204);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("pp_imm", Imm, 12'h0FF);
        chk("pp_rd", Rd, 2);
        chk("pp_ready", InstrReady, 1);
        chk("pp_pc", PCOut, 32'h204);
        tick();
        chk("pp_was_one", DecValid, 0);

        // flush from FULL discards the concurrent push
        DecReady = 1'b0;
        drive(1'b1, 32'hE1A00000, 32'h300);
        tick();
        drive(1'b1, 32'hE1A01001, 32'h304);
        tick();
        chk("fl_full", InstrReady, 0);
        Flush = 1'b1; DecReady = 1'b1;
        drive(1'b1, 32'hE1A02002, 32'h308);
        tick();
        Flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0);
        chk("fl_decvalid", DecValid, 0);
        chk("fl_ready", InstrReady, 1);
        tick();
        chk("fl_still_empty", DecValid, 0);
        drive(1'b1, 32'hE1A03003, 32'h30C);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("fl_new_head", Instr, 32'hE1A03003);
        chk("fl_new_pc", PCOut, 32'h30C);
        tick();
        chk("fl_new_drained", DecValid, 0);

        // async reset between edges while FULL and stalled
        DecReady = 1'b0;
        drive(1'b1, 32'hE0811002, 32'h400);
        tick();
        drive(1'b1, 32'hE0822003, 32'h404);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("ar_full", InstrReady, 0);
        #2;
        reset = 1'b1;
        #1;
        chk("ar_decvalid", DecValid, 0);
        chk("ar_instr", Instr, 0);
        chk("ar_pc", PCOut, 0);
        chk("ar_ready", InstrReady, 1);
        chk("ar_stall", StallCount, 0);
        #1;
        reset = 1'b0;
        tick();
        chk("ar_after_valid", DecValid, 0);

        // stall counter: 7 stalled cycles, then a non-stalled flush
        DecReady = 1'b0;
        drive(1'b1, 32'hE3A04004, 32'h500);
        tick();
        drive(1'b0, 32'h0, 32'h0);
        chk("sc_start", StallCount, 0);
        repeat (7) tick();
        chk("sc_seven", StallCount, PERF ? 7 : 0);
        chk("sc_held_head", Instr, 32'hE3A04004);
        Flush = 1'b1; DecReady = 1'b1;
        tick();
        Flush = 1'b0;
        chk("sc_flush_keep", StallCount, PERF ? 7 : 0);
        chk("sc_flush_valid", DecValid, 0);
        DecReady = 1'b0;
        repeat (3) tick();
        chk("sc_idle_keep", StallCount, PERF ? 7 : 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
